mcpu_ctrl: RTL and testbench
============================

MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high (fixed).
REQ-003 SHALL: opcode  in  6  instruction[31:26], valid from DECODE onward; funct  in  6  instruction[5:0].
REQ-004 SHALL: zero  in  1  and  overflow  in  1  from the ALU, sampled in the state that uses them.
REQ-005 SHALL: mem_ready  in  1  memory completion for the current mem_req.
REQ-006 SHALL: mem_req  out  1  and  mem_we  out  1  memory request and write enable; iord  out  1  (0 = PC address, 1 = ALU result address).
REQ-007 SHALL: ir_write  out  1  instruction-register load; pc_write  out  1; pc_src  out  2  (0 ALU result, 1 ALU-out register, 2 jump target).
REQ-008 SHALL: alu_src_a  out  2  (0 PC, 1 rs, 2 shamt); alu_src_b  out  2  (0 rt, 1 const 4, 2 imm, 3 imm<<2); imm_zext  out  1  (1 = zero-extend imm).
REQ-009 SHALL: alu_op  out  4  (0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL, 6 SUB, 7 SLT, 8 SLL).
REQ-010 SHALL: reg_write  out  1; reg_dst  out  2  (0 rt, 1 rd, 2 r31); mem_to_reg  out  1; state  out  4  current state, debug; exc  out  1  one-cycle fault pulse.

Function
REQ-011 SHALL: Moore FSM, all outputs decoded from state plus registered opcode/funct only; zero/overflow gate pc_write/transitions only.
REQ-012 SHALL: states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
REQ-013 SHALL: FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD; stay until mem_ready=1, then in that cycle ir_write=1, pc_write=1, pc_src=0, next DECODE.
REQ-014 SHALL: DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALU-out); next by opcode: 0x00->EXEC_R, 0x08/0x0A/0x0C/0x0D/0x0E->EXEC_I, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x02/0x03->JUMP, other->TRAP.
REQ-015 SHALL: EXEC_R funct map: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL; shifts use alu_src_a=2, alu_src_b=0, others alu_src_a=1, alu_src_b=0; unknown funct->TRAP; else next WB_ALU.
REQ-016 SHALL: EXEC_I: alu_src_a=1, alu_src_b=2; addi ADD, slti SLT, andi AND, ori OR, xori XOR; imm_zext=1 for andi/ori/xori; next WB_ALU.
REQ-017 SHALL: WB_ALU: reg_write=1, reg_dst=1 for R-type else 0, mem_to_reg=0; next FETCH.
REQ-018 SHALL: MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; next MEM_RD (lw) or MEM_WR (sw).
REQ-019 SHALL: MEM_RD/MEM_WR: mem_req=1, iord=1, mem_we=1 only in MEM_WR; hold until mem_ready; then MEM_RD->WB_MEM, MEM_WR->FETCH.
REQ-020 SHALL: WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-021 SHALL: BRANCH: alu_src_a=1, alu_src_b=0, SUB; pc_write=(zero XOR bne), pc_src=1; next FETCH.
REQ-022 SHALL: JUMP: pc_write=1, pc_src=2; jal additionally reg_write=1, reg_dst=2 (link value selected by datapath); next FETCH.
REQ-023 SHALL: TRAP: exc=1 for exactly one cycle, no reg_write/pc_write/mem_req; next FETCH.
REQ-024 SHALL: cycle counts (mem_ready immediate): R/I-ALU 4, lw 5, sw 4, beq/bne/j/jal 3, trap 3.
REQ-025 SHALL: mem_ready while mem_req=0 is ignored; mem_req stays high until mem_ready seen.

Reset
REQ-026 SHALL: rst=1 at any posedge, including mid-memory-wait, forces state=FETCH and all outputs 0 the following cycle except FETCH decodes; rst overrides mem_ready.
REQ-027 SHALL: outputs while rst is held equal FETCH decodes, but pc_write and ir_write are forced 0.

Configuration
REQ-028 SHALL: macro MCPU_OVF_TRAP_EN defined: in EXEC_R/EXEC_I for add/sub/addi (not addu/subu), overflow=1 routes to TRAP instead of WB_ALU, suppressing the write.
REQ-029 SHALL: macro undefined: overflow input ignored; all ALU instructions proceed to WB_ALU.

Structure
REQ-030 SHALL: package mcpu_pkg holds state encoding, alu_op codes, opcode/funct constants, mux select codes.
REQ-031 SHALL: combinational sub-module mcpu_alu_dec maps (state, opcode, funct) to alu_op.

Verification
REQ-032 SHALL: add (op 0x00, funct 0x20), mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_op=2),WB_ALU(reg_write=1, reg_dst=1), 4 cycles.
REQ-033 SHALL: lw with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, iord=1, WB_MEM mem_to_reg=1.
REQ-034 SHALL: beq zero=1 -> pc_write=1 pc_src=1; bne zero=1 -> pc_write=0.
REQ-035 SHALL: add with overflow=1 -> TRAP, exc pulse 1 cycle, no reg_write (MCPU_OVF_TRAP_EN); WB_ALU without macro.
REQ-036 SHALL: opcode 0x3F -> TRAP; rst asserted during MEM_WR wait -> FETCH next cycle, mem_we=0.

Source files
------------

// File: rtl/mcpu_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_pkg -- shared definitions for the multi-cycle CPU control unit.
//   state_e    : FSM state encoding (also driven out on the debug state port)
//   alu_op_e   : ALU operation codes presented on alu_op
//   OP_* / F_* : opcode (instr[31:26]) and R-type funct (instr[5:0]) values
//   *_SEL      : datapath multiplexer select codes
// Helper functions classify funct and opcode values.
// -----------------------------------------------------------------------------
package mcpu_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_TRAP     = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8
  } alu_op_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // Mux select codes
  localparam logic [1:0] SRC_A_PC      = 2'd0;
  localparam logic [1:0] SRC_A_RS      = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT   = 2'd2;
  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_R31   = 2'd2;

  function automatic logic is_shift_funct(input logic [5:0] f);
    return (f == F_SLL) || (f == F_SRL);
  endfunction

  function automatic logic is_known_funct(input logic [5:0] f);
    logic known;
    case (f)
      F_SLL, F_SRL, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_XOR, F_NOR, F_SLT: known = 1'b1;
      default:                          known = 1'b0;
    endcase
    return known;
  endfunction

  // Only the signed add/sub forms raise an overflow fault; addu/subu never do.
  function automatic logic is_ovf_checked_funct(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB);
  endfunction

  function automatic logic is_i_alu_op(input logic [5:0] op);
    logic hit;
    case (op)
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: hit = 1'b1;
      default:                                   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// -----------------------------------------------------------------------------
// mcpu_alu_dec -- combinational ALU operation decoder.
//   state  in  4 : effective FSM state (FETCH while reset is held)
//   opcode in  6 : registered instruction opcode
//   funct  in  6 : registered R-type funct field
//   alu_op out 4 : ALU operation code (mcpu_pkg::alu_op_e)
// States that do not use the ALU drive AND (code 0).
// -----------------------------------------------------------------------------
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  state_e st;
  assign st = state_e'(state);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    alu_op = ALU_AND;
    case (st)
      ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_op = ALU_ADD;
      ST_BRANCH:                        alu_op = ALU_SUB;
      ST_EXEC_I: begin
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_XORI: alu_op = ALU_XOR;
          default: alu_op = ALU_AND;
        endcase
      end
      ST_EXEC_R: begin
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLL:         alu_op = ALU_SLL;
          F_SRL:         alu_op = ALU_SRL;
          default:       alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// mcpu_ctrl -- Moore-style control FSM for a multi-cycle MIPS-like datapath.
//
// Ports
//   clk, rst (sync, active-high)
//   opcode[5:0], funct[5:0]   instruction fields, valid from DECODE onward
//   zero, overflow            ALU flags, sampled in the state that uses them
//   mem_ready                 completion of the current memory request
//   mem_req, mem_we, iord     memory request / write enable / address select
//   ir_write, pc_write        IR load and PC load strobes
//   pc_src[1:0]               0 ALU result, 1 ALU-out register, 2 jump target
//   alu_src_a[1:0]            0 PC, 1 rs, 2 shamt
//   alu_src_b[1:0]            0 rt, 1 const 4, 2 imm, 3 imm<<2
//   imm_zext                  zero-extend immediate (andi/ori/xori)
//   alu_op[3:0]               ALU operation (see mcpu_pkg::alu_op_e)
//   reg_write, reg_dst[1:0]   register write; dest 0 rt, 1 rd, 2 r31
//   mem_to_reg                write-back source is memory data
//   state[3:0]                current state (debug)
//   exc                       one-cycle fault pulse (TRAP)
//
// Configuration macro: MCPU_OVF_TRAP_EN -- when defined, signed add/sub/addi
// with overflow=1 go to TRAP instead of WB_ALU. Undefined: overflow ignored.
// -----------------------------------------------------------------------------
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       exc
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;

  // While reset is held the outputs decode as FETCH, whatever the register
  // still holds; the write strobes are additionally masked below.
  state_e dec_state;
  assign dec_state = rst ? ST_FETCH : state_q;

  // Instruction fields are captured on leaving DECODE so the later states
  // decode from local registers rather than the live IR inputs.
  assign opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;
  assign funct_d  = (state_q == ST_DECODE) ? funct  : funct_q;

  logic ovf_trap_r, ovf_trap_i;
`ifdef MCPU_OVF_TRAP_EN
  assign ovf_trap_r = overflow & is_ovf_checked_funct(funct_q);
  assign ovf_trap_i = overflow & (opcode_q == OP_ADDI);
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign ovf_trap_r      = 1'b0;
  assign ovf_trap_i      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  // Next-state logic. Reset is applied in the register, so it overrides
  // mem_ready without any special case here.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                                    state_d = ST_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:                                state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                              state_d = ST_BRANCH;
          OP_J, OP_JAL:                                state_d = ST_JUMP;
          default:                                     state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        if (!is_known_funct(funct_q) || ovf_trap_r) state_d = ST_TRAP;
        else                                        state_d = ST_WB_ALU;
      end
      ST_EXEC_I:   state_d = ovf_trap_i ? ST_TRAP : ST_WB_ALU;
      ST_MEM_ADDR: state_d = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_TRAP: state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Output decode from the (effective) state and the registered fields.
  // mem_ready and zero only gate the PC/IR write strobes.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    imm_zext   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = 1'b0;
    exc        = 1'b0;
    case (dec_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready & ~rst;
        pc_write  = mem_ready & ~rst;
        pc_src    = PC_SRC_ALU;
      end
      ST_DECODE: alu_src_b = SRC_B_IMM_SH2;
      ST_EXEC_R: begin
        alu_src_a = is_shift_funct(funct_q) ? SRC_A_SHAMT : SRC_A_RS;
        alu_src_b = SRC_B_RT;
      end
      ST_EXEC_I: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
        imm_zext  = (opcode_q == OP_ANDI) || (opcode_q == OP_ORI) ||
                    (opcode_q == OP_XORI);
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode_q == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = SRC_A_RS;
        alu_src_b = SRC_B_RT;
        // beq takes the branch on zero, bne on not-zero.
        pc_write  = zero ^ (opcode_q == OP_BNE);
        pc_src    = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        if (opcode_q == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_R31;
        end
      end
      ST_TRAP: exc = 1'b1;
      default: ;
    endcase
  end

  mcpu_alu_dec u_alu_dec (
    .state  (dec_state),
    .opcode (opcode_q),
    .funct  (funct_q),
    .alu_op (alu_op)
  );

  assign state = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcpu_ctrl -- self-checking bench for mcpu_ctrl.
// Directed table of whole instructions, hand-written multi-cycle sequences
// (reset, delayed lw, reset during a store wait) and randomized instruction
// streams compared against a phase-list reference model.
// -----------------------------------------------------------------------------
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, imm_zext;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst;
  logic [3:0] alu_op, state;
  logic       reg_write, mem_to_reg, exc;

  mcpu_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state), .exc(exc)
  );

  always #5 clk = ~clk;

`ifdef MCPU_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // Phase numbers follow the order the states are listed in the requirements.
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3,
                 P_MEM_ADDR = 4, P_MEM_RD = 5, P_MEM_WR = 6, P_WB_ALU = 7,
                 P_WB_MEM = 8, P_BRANCH = 9, P_JUMP = 10, P_TRAP = 11;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, exc;
  } obs_t;

  obs_t act;
  assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, imm_zext, alu_op, reg_write, reg_dst,
                mem_to_reg, exc};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an instruction is a list of phases; each phase has a
  // fixed output pattern taken from the requirement text.
  // ---------------------------------------------------------------------------
  logic [5:0] r_functs [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
  logic [5:0] i_ops [5]     = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

  int phases[$];

  function automatic logic funct_legal(input logic [5:0] fn);
    for (int i = 0; i < 11; i++) if (r_functs[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_phases(input logic [5:0] op, input logic [5:0] fn,
                              input logic ovf);
    phases.delete();
    phases.push_back(P_FETCH);
    phases.push_back(P_DECODE);
    case (op)
      6'h00: begin
        phases.push_back(P_EXEC_R);
        if (!funct_legal(fn) || (OVF_EN && ovf && (fn == 6'h20 || fn == 6'h22)))
          phases.push_back(P_TRAP);
        else
          phases.push_back(P_WB_ALU);
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        phases.push_back(P_EXEC_I);
        phases.push_back((OVF_EN && ovf && op == 6'h08) ? P_TRAP : P_WB_ALU);
      end
      6'h23: begin
        phases.push_back(P_MEM_ADDR); phases.push_back(P_MEM_RD);
        phases.push_back(P_WB_MEM);
      end
      6'h2B: begin phases.push_back(P_MEM_ADDR); phases.push_back(P_MEM_WR); end
      6'h04, 6'h05: phases.push_back(P_BRANCH);
      6'h02, 6'h03: phases.push_back(P_JUMP);
      default:      phases.push_back(P_TRAP);
    endcase
  endtask

  function automatic obs_t model_out(input int ph, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z,
                                     input logic mr);
    obs_t o = '0;
    o.state = 4'(ph);
    case (ph)
      P_FETCH: begin
        o.mem_req = 1; o.alu_src_b = 2'd1; o.alu_op = 4'd2;
        o.ir_write = mr; o.pc_write = mr;
      end
      P_DECODE: begin o.alu_src_b = 2'd3; o.alu_op = 4'd2; end
      P_EXEC_R: begin
        o.alu_src_a = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1;
        case (fn)
          6'h20, 6'h21: o.alu_op = 4'd2;
          6'h22, 6'h23: o.alu_op = 4'd6;
          6'h24: o.alu_op = 4'd0;
          6'h25: o.alu_op = 4'd1;
          6'h26: o.alu_op = 4'd3;
          6'h27: o.alu_op = 4'd4;
          6'h2A: o.alu_op = 4'd7;
          6'h00: o.alu_op = 4'd8;
          6'h02: o.alu_op = 4'd5;
          default: o.alu_op = 4'd0;
        endcase
      end
      P_EXEC_I: begin
        o.alu_src_a = 2'd1; o.alu_src_b = 2'd2;
        case (op)
          6'h08: o.alu_op = 4'd2;
          6'h0A: o.alu_op = 4'd7;
          6'h0C: o.alu_op = 4'd0;
          6'h0D: o.alu_op = 4'd1;
          default: o.alu_op = 4'd3;
        endcase
        o.imm_zext = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
      end
      P_MEM_ADDR: begin o.alu_src_a = 2'd1; o.alu_src_b = 2'd2; o.alu_op = 4'd2; end
      P_MEM_RD:   begin o.mem_req = 1; o.iord = 1; end
      P_MEM_WR:   begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; end
      P_WB_ALU:   begin o.reg_write = 1; o.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0; end
      P_WB_MEM:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_BRANCH: begin
        o.alu_src_a = 2'd1; o.alu_op = 4'd6; o.pc_src = 2'd1;
        o.pc_write = z ^ (op == 6'h05);
      end
      P_JUMP: begin
        o.pc_write = 1; o.pc_src = 2'd2;
        if (op == 6'h03) begin o.reg_write = 1; o.reg_dst = 2'd2; end
      end
      P_TRAP: o.exc = 1;
      default: ;
    endcase
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed instruction table (mem_ready immediate).
  // alu3 is alu_op in the third cycle; bit 4 set means not checked.
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic       z, ovf;
    int         cycles;
    logic       wr;
    logic [1:0] dst;
    logic       pcw;
    int         excs;
    logic [4:0] alu3;
  } vec_t;

  vec_t vecs[$];

  task automatic reset_dut();
    rst = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    obs_t exp_o;
    int   reqc;

    vecs.push_back('{"add",      6'h00, 6'h20, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h02});
    vecs.push_back('{"addu_ovf", 6'h00, 6'h21, 1'b0, 1'b1, 4, 1'b1, 2'd1, 1'b0, 0, 5'h02});
    vecs.push_back('{"subu",     6'h00, 6'h23, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h06});
    vecs.push_back('{"sll",      6'h00, 6'h00, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h08});
    vecs.push_back('{"srl",      6'h00, 6'h02, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h05});
    vecs.push_back('{"slt",      6'h00, 6'h2A, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h07});
    vecs.push_back('{"nor",      6'h00, 6'h27, 1'b0, 1'b0, 4, 1'b1, 2'd1, 1'b0, 0, 5'h04});
    vecs.push_back('{"bad_fn",   6'h00, 6'h3F, 1'b0, 1'b0, 4, 1'b0, 2'd0, 1'b0, 1, 5'h10});
    vecs.push_back('{"addi",     6'h08, 6'h15, 1'b0, 1'b0, 4, 1'b1, 2'd0, 1'b0, 0, 5'h02});
    vecs.push_back('{"ori",      6'h0D, 6'h00, 1'b0, 1'b0, 4, 1'b1, 2'd0, 1'b0, 0, 5'h01});
    vecs.push_back('{"slti",     6'h0A, 6'h00, 1'b0, 1'b0, 4, 1'b1, 2'd0, 1'b0, 0, 5'h07});
    vecs.push_back('{"lw",       6'h23, 6'h00, 1'b0, 1'b0, 5, 1'b1, 2'd0, 1'b0, 0, 5'h02});
    vecs.push_back('{"sw",       6'h2B, 6'h00, 1'b0, 1'b0, 4, 1'b0, 2'd0, 1'b0, 0, 5'h02});
    vecs.push_back('{"beq_z1",   6'h04, 6'h00, 1'b1, 1'b0, 3, 1'b0, 2'd0, 1'b1, 0, 5'h06});
    vecs.push_back('{"beq_z0",   6'h04, 6'h00, 1'b0, 1'b0, 3, 1'b0, 2'd0, 1'b0, 0, 5'h06});
    vecs.push_back('{"bne_z1",   6'h05, 6'h00, 1'b1, 1'b0, 3, 1'b0, 2'd0, 1'b0, 0, 5'h06});
    vecs.push_back('{"bne_z0",   6'h05, 6'h00, 1'b0, 1'b0, 3, 1'b0, 2'd0, 1'b1, 0, 5'h06});
    vecs.push_back('{"j",        6'h02, 6'h00, 1'b0, 1'b0, 3, 1'b0, 2'd0, 1'b1, 0, 5'h10});
    vecs.push_back('{"jal",      6'h03, 6'h00, 1'b0, 1'b0, 3, 1'b1, 2'd2, 1'b1, 0, 5'h10});
    vecs.push_back('{"op3f",     6'h3F, 6'h00, 1'b0, 1'b0, 3, 1'b0, 2'd0, 1'b0, 1, 5'h10});
    vecs.push_back('{"addiu",    6'h09, 6'h00, 1'b0, 1'b0, 3, 1'b0, 2'd0, 1'b0, 1, 5'h10});
`ifdef MCPU_OVF_TRAP_EN
    vecs.push_back('{"add_ovf",  6'h00, 6'h20, 1'b0, 1'b1, 4, 1'b0, 2'd0, 1'b0, 1, 5'h02});
    vecs.push_back('{"sub_ovf",  6'h00, 6'h22, 1'b0, 1'b1, 4, 1'b0, 2'd0, 1'b0, 1, 5'h06});
    vecs.push_back('{"addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1, 4, 1'b0, 2'd0, 1'b0, 1, 5'h02});
`else
    vecs.push_back('{"add_ovf",  6'h00, 6'h20, 1'b0, 1'b1, 4, 1'b1, 2'd1, 1'b0, 0, 5'h02});
    vecs.push_back('{"sub_ovf",  6'h00, 6'h22, 1'b0, 1'b1, 4, 1'b1, 2'd1, 1'b0, 0, 5'h06});
    vecs.push_back('{"addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1, 4, 1'b1, 2'd0, 1'b0, 0, 5'h02});
`endif

    opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;

    // ---- Reset: outputs are FETCH decodes with the write strobes masked ----
    rst = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("reset_hold", 32'(act), 32'(model_out(P_FETCH, 6'h00, 6'h00, 1'b0, 1'b0)));
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("after_reset", 32'(act), 32'(model_out(P_FETCH, 6'h00, 6'h00, 1'b0, 1'b0)));
    tick();

    // ---- Directed table ----
    foreach (vecs[vi]) begin
      int   cyc, excs;
      logic wr_seen, pcw_seen, done;
      logic [1:0] dst_seen;
      logic [3:0] alu3;
      cyc = 0; excs = 0; wr_seen = 0; pcw_seen = 0; done = 0; dst_seen = 0; alu3 = 0;
      opcode = vecs[vi].op; funct = vecs[vi].fn; zero = vecs[vi].z;
      overflow = vecs[vi].ovf; mem_ready = 1'b1;
      while (!done && cyc < 20) begin
        @(negedge clk);
        if (reg_write) begin wr_seen = 1; dst_seen = reg_dst; end
        if (cyc > 0 && pc_write) pcw_seen = 1;
        if (exc) excs++;
        if (cyc == 2) alu3 = alu_op;
        tick();
        cyc++;
        if (state == 4'd0) done = 1;
      end
      check({vecs[vi].name, ".cycles"}, 32'(cyc), 32'(vecs[vi].cycles));
      check({vecs[vi].name, ".reg_write"}, 32'(wr_seen), 32'(vecs[vi].wr));
      if (vecs[vi].wr) check({vecs[vi].name, ".reg_dst"}, 32'(dst_seen), 32'(vecs[vi].dst));
      check({vecs[vi].name, ".pc_write"}, 32'(pcw_seen), 32'(vecs[vi].pcw));
      check({vecs[vi].name, ".exc_cycles"}, 32'(excs), 32'(vecs[vi].excs));
      if (!vecs[vi].alu3[4]) check({vecs[vi].name, ".alu_op"}, 32'(alu3), 32'(vecs[vi].alu3[3:0]));
      if (!done) reset_dut();
    end
    zero = 1'b0; overflow = 1'b0;

    // ---- lw with mem_ready held off for 3 cycles in MEM_RD ----
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    tick(); tick(); tick();          // FETCH, DECODE, MEM_ADDR
    reqc = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      if (mem_req && iord && state == 4'd5) reqc++;
      tick();
    end
    check("lw_wait.mem_req_cycles", 32'(reqc), 32'd4);
    mem_ready = 1'b0;
    @(negedge clk);
    check("lw_wait.wb_mem", 32'(act), 32'(model_out(P_WB_MEM, 6'h23, 6'h00, 1'b0, 1'b0)));
    tick();
    @(negedge clk);
    check("lw_wait.back_to_fetch", 32'(state), 32'd0);

    // ---- reset asserted while a store waits for memory ----
    opcode = 6'h2B; mem_ready = 1'b1;
    tick(); tick(); tick();          // FETCH, DECODE, MEM_ADDR
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_wait.mem_wr", 32'(act), 32'(model_out(P_MEM_WR, 6'h2B, 6'h00, 1'b0, 1'b0)));
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    exp_o = model_out(P_FETCH, 6'h2B, 6'h00, 1'b0, 1'b0);
    exp_o.state = 4'(P_MEM_WR);
    check("sw_rst.hold_outputs", 32'(act), 32'(exp_o));
    tick();
    @(negedge clk);
    check("sw_rst.next_cycle", 32'(act), 32'(model_out(P_FETCH, 6'h2B, 6'h00, 1'b0, 1'b0)));
    tick();
    rst = 1'b0; mem_ready = 1'b0;

    // ---- Randomized instruction stream against the phase-list model ----
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      logic       ovf;
      int         sel;
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom);
      case (sel)
        0, 1, 2: begin op = 6'h00; fn = r_functs[$urandom_range(0, 10)]; end
        3, 4:    op = i_ops[$urandom_range(0, 4)];
        5:       op = 6'h23;
        6:       op = 6'h2B;
        7:       op = 6'($urandom_range(4, 5));
        8:       op = 6'($urandom_range(2, 3));
        default: op = 6'($urandom);
      endcase
      ovf = 1'($urandom_range(0, 1));
      build_phases(op, fn, ovf);
      foreach (phases[pi]) begin
        int   ph, w;
        logic is_mem;
        ph     = phases[pi];
        is_mem = (ph == P_FETCH || ph == P_MEM_RD || ph == P_MEM_WR);
        w      = is_mem ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= w; k++) begin
          mem_ready = is_mem ? (k == w) : 1'($urandom_range(0, 1));
          zero      = 1'($urandom_range(0, 1));
          overflow  = (ph == P_EXEC_R || ph == P_EXEC_I) ? ovf : 1'($urandom_range(0, 1));
          opcode    = (ph == P_FETCH) ? 6'($urandom) : op;
          funct     = (ph == P_FETCH) ? 6'($urandom) : fn;
          @(negedge clk);
          check("random", 32'(act), 32'(model_out(ph, op, fn, zero, mem_ready)));
          tick();
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
